// File: rtl/barcode_seq_drv.sv
// Playback sequencer for the iCE40UP barcode current-sink driver: buffers {level, duration}
// elements, then drives CURREN/BARCODEEN/BARCODEPWM with bias settle and ordered shutdown.
module barcode_seq_drv #(
    parameter int ELEM_W      = 16,
    parameter int DEPTH       = 8,
    parameter int BIAS_WAIT   = 4800,
    parameter int CARRIER_DIV = 0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         WR_EN,
    input  logic [ELEM_W:0]              WR_DATA,
    output logic                         WR_READY,
    input  logic                         CLR,
    input  logic                         START,
    input  logic [7:0]                   REPEAT,
    input  logic                         ABORT,
    output logic                         BUSY,
    output logic                         DONE,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         CURREN,
    output logic                         BARCODEEN,
    output logic                         BARCODEPWM
);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int IW  = $clog2(DEPTH);
    localparam int BW  = $clog2(BIAS_WAIT+1);
    localparam int CAW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

    typedef enum logic [1:0] {IDLE, BIAS, PLAY, OFF} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     count, count_n;
    logic [BW-1:0]     bias_cnt, bias_n;
    logic [IW-1:0]     idx, idx_n;
    logic [ELEM_W-1:0] dur_cnt, dur_n;
    logic [7:0]        pass_cnt, pass_n;
    logic [CAW-1:0]    car_cnt, car_n;
    logic              phase, ph_n;
    logic              done_n, pwm_n, wr_acc;

    logic [ELEM_W:0]   mem [DEPTH];

    assign COUNT    = count;
    assign WR_READY = (state == IDLE) && (count < CW'(DEPTH));

    // Buffer contents are never reset; COUNT alone defines what is valid.
    always_ff @(posedge CLK) begin
        if (wr_acc) mem[count[IW-1:0]] <= WR_DATA;
    end

    always_comb begin
        state_n = state;
        count_n = count;
        bias_n  = bias_cnt;
        idx_n   = idx;
        dur_n   = dur_cnt;
        pass_n  = pass_cnt;
        car_n   = car_cnt;
        ph_n    = phase;
        done_n  = 1'b0;
        wr_acc  = 1'b0;
        case (state)
            IDLE: begin
                if (CLR) begin
                    count_n = '0;
                end else if (WR_EN && count < CW'(DEPTH)) begin
                    wr_acc  = 1'b1;
                    count_n = count + CW'(1);
                end
                if (START) begin
                    if (count_n == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = BIAS;
                        bias_n  = BW'(BIAS_WAIT - 1);
                        pass_n  = REPEAT;
                    end
                end
            end
            BIAS: begin
                if (ABORT) begin
                    state_n = OFF;
                end else if (bias_cnt == '0) begin
                    state_n = PLAY;
                    idx_n   = '0;
                    dur_n   = mem[0][ELEM_W-1:0];
                    car_n   = '0;
                    ph_n    = 1'b1;
                end else begin
                    bias_n = bias_cnt - BW'(1);
                end
            end
            PLAY: begin
                if (ABORT) begin
                    state_n = OFF;
                end else if (dur_cnt == '0) begin
                    // Element boundary: carrier phase restarts high on every element.
                    car_n = '0;
                    ph_n  = 1'b1;
                    if (CW'(idx) == count - CW'(1)) begin
                        idx_n = '0;
                        if (pass_cnt == '0) state_n = OFF;
                        else                pass_n  = pass_cnt - 8'd1;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                    dur_n = mem[idx_n][ELEM_W-1:0];
                end else begin
                    dur_n = dur_cnt - ELEM_W'(1);
                    if (car_cnt == CAW'(CARRIER_DIV - 1)) begin
                        car_n = '0;
                        ph_n  = ~phase;
                    end else begin
                        car_n = car_cnt + CAW'(1);
                    end
                end
            end
            OFF: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        pwm_n = (state_n == PLAY) && mem[idx_n][ELEM_W] && ((CARRIER_DIV == 0) || ph_n);
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            count      <= '0;
            bias_cnt   <= '0;
            idx        <= '0;
            dur_cnt    <= '0;
            pass_cnt   <= '0;
            car_cnt    <= '0;
            phase      <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            CURREN     <= 1'b0;
            BARCODEEN  <= 1'b0;
            BARCODEPWM <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            bias_cnt   <= bias_n;
            idx        <= idx_n;
            dur_cnt    <= dur_n;
            pass_cnt   <= pass_n;
            car_cnt    <= car_n;
            phase      <= ph_n;
            BUSY       <= (state_n != IDLE);
            DONE       <= done_n;
            CURREN     <= (state_n != IDLE);
            BARCODEEN  <= (state_n == PLAY);
            BARCODEPWM <= pwm_n;
        end
    end
endmodule

// File: tb/tb_barcode_seq_drv.sv
// Bench for barcode_seq_drv: two instances (no carrier / CARRIER_DIV=2) share stimulus and are
// compared cycle by cycle with a waveform list built from the element list.
module tb_barcode_seq_drv;
    logic        CLK = 1'b0;
    logic        RST, WR_EN, CLR, START, ABORT;
    logic [16:0] WR_DATA;
    logic [7:0]  REPEAT;
    logic        WR_READY, BUSY, DONE, CURREN, BARCODEEN, BARCODEPWM;
    logic [2:0]  COUNT;
    logic        c_wr_ready, c_busy, c_done, c_curren, c_en, c_pwm;
    logic [2:0]  c_count;

    int checks = 0;
    int errors = 0;
    logic [16:0] mq[$];

    always #5 CLK = ~CLK;

    barcode_seq_drv #(.ELEM_W(16), .DEPTH(4), .BIAS_WAIT(4), .CARRIER_DIV(0)) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
        .CLR(CLR), .START(START), .REPEAT(REPEAT), .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE),
        .COUNT(COUNT), .CURREN(CURREN), .BARCODEEN(BARCODEEN), .BARCODEPWM(BARCODEPWM));

    barcode_seq_drv #(.ELEM_W(16), .DEPTH(4), .BIAS_WAIT(4), .CARRIER_DIV(2)) dut_c (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_READY(c_wr_ready),
        .CLR(CLR), .START(START), .REPEAT(REPEAT), .ABORT(ABORT), .BUSY(c_busy), .DONE(c_done),
        .COUNT(c_count), .CURREN(c_curren), .BARCODEEN(c_en), .BARCODEPWM(c_pwm));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_count(input string tag);
        chk({tag, "_count"}, COUNT, mq.size());
        chk({tag, "_c_count"}, c_count, mq.size());
    endtask

    task automatic do_clr();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        mq.delete();
        chk_count("clr");
    endtask

    task automatic wr(input logic lvl, input int dur);
        WR_EN   = 1'b1;
        WR_DATA = {lvl, 16'(dur)};
        step();
        WR_EN = 1'b0;
        if (mq.size() < 4) mq.push_back({lvl, 16'(dur)});
        chk_count("wr");
    endtask

    // Expected entry per cycle: {curren, en, pwm_nocarrier, pwm_div2, done, busy}
    task automatic play(input int rep, input int abort_at, input bit with_wr, input bit with_clr,
                        input logic [16:0] wd);
        logic [5:0] q[$];
        logic [5:0] e;
        logic       lvl;
        if (with_clr) mq.delete();
        else if (with_wr && mq.size() < 4) mq.push_back(wd);
        if (mq.size() > 0) begin
            repeat (4) q.push_back(6'b100001);
            for (int p = 0; p <= rep; p++)
                foreach (mq[i]) begin
                    lvl = mq[i][16];
                    for (int c = 0; c <= int'(mq[i][15:0]); c++)
                        q.push_back({2'b11, lvl, lvl && ((c / 2) % 2 == 0), 2'b01});
                end
            if (abort_at > 0 && abort_at <= q.size())
                while (q.size() > abort_at) void'(q.pop_back());
            q.push_back(6'b100001);
        end
        q.push_back(6'b000010);
        q.push_back(6'b000000);

        START = 1'b1; REPEAT = 8'(rep); WR_EN = with_wr; WR_DATA = wd; CLR = with_clr;
        step();
        START = 1'b0; WR_EN = 1'b0; CLR = 1'b0;
        for (int k = 1; k <= q.size(); k++) begin
            e = q[k-1];
            chk($sformatf("curren@t+%0d", k), CURREN, e[5]);
            chk($sformatf("en@t+%0d", k), BARCODEEN, e[4]);
            chk($sformatf("pwm@t+%0d", k), BARCODEPWM, e[3]);
            chk($sformatf("done@t+%0d", k), DONE, e[1]);
            chk($sformatf("busy@t+%0d", k), BUSY, e[0]);
            chk($sformatf("ready@t+%0d", k), WR_READY, !e[0] && mq.size() < 4);
            chk($sformatf("c_curren@t+%0d", k), c_curren, e[5]);
            chk($sformatf("c_en@t+%0d", k), c_en, e[4]);
            chk($sformatf("c_pwm@t+%0d", k), c_pwm, e[2]);
            chk($sformatf("c_done@t+%0d", k), c_done, e[1]);
            chk_count($sformatf("play@t+%0d", k));
            ABORT = (k == abort_at);
            step();
        end
        ABORT = 1'b0;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_curren"}, CURREN, 1'b0);
        chk({tag, "_en"}, BARCODEEN, 1'b0);
        chk({tag, "_pwm"}, BARCODEPWM, 1'b0);
        chk({tag, "_done"}, DONE, 1'b0);
        chk({tag, "_busy"}, BUSY, 1'b0);
        chk({tag, "_c_curren"}, c_curren, 1'b0);
        chk({tag, "_c_pwm"}, c_pwm, 1'b0);
        chk_count(tag);
    endtask

    initial begin
        RST = 1'b1; WR_EN = 1'b0; CLR = 1'b0; START = 1'b0; ABORT = 1'b0;
        WR_DATA = '0; REPEAT = '0;
        step();
        chk_idle_zero("in_reset");
        step();
        RST = 1'b0;
        step();
        chk_idle_zero("reset");
        chk("reset_ready", WR_READY, 1'b1);

        // Basic pattern, single pass, then three passes
        wr(1'b1, 2); wr(1'b0, 0); wr(1'b1, 1);
        play(0, 0, 1'b0, 1'b0, '0);
        play(2, 0, 1'b0, 1'b0, '0);

        // Full buffer drops writes; CLR empties; empty START only pulses DONE
        wr(1'b1, 3);
        wr(1'b0, 1);
        chk("full_ready", WR_READY, 1'b0);
        do_clr();
        chk("clr_ready", WR_READY, 1'b1);
        play(0, 0, 1'b0, 1'b0, '0);

        // ABORT during PLAY
        wr(1'b1, 2); wr(1'b0, 0); wr(1'b1, 1);
        play(0, 7, 1'b0, 1'b0, '0);
        play(1, 2, 1'b0, 1'b0, '0);

        // RST mid-playback drops outputs at once and empties the buffer
        START = 1'b1; REPEAT = 8'd0;
        step();
        START = 1'b0;
        repeat (5) step();
        chk("pre_rst_en", BARCODEEN, 1'b1);
        #2 RST = 1'b1;
        #1;
        mq.delete();
        chk_idle_zero("mid_rst");
        @(negedge CLK);
        RST = 1'b0;
        step();
        chk_idle_zero("post_rst");

        // Carrier patterns: long bar then a space
        wr(1'b1, 7);
        play(0, 0, 1'b0, 1'b0, '0);
        do_clr();
        wr(1'b0, 3);
        play(0, 0, 1'b0, 1'b0, '0);

        // START together with WR_EN, then START together with CLR
        do_clr();
        wr(1'b1, 1);
        play(0, 0, 1'b1, 1'b0, {1'b1, 16'd2});
        play(0, 0, 1'b0, 1'b1, '0);

        // Randomized element lists, repeat counts and aborts
        for (int it = 0; it < 10; it++) begin
            int n, ab;
            do_clr();
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) wr(1'($urandom_range(0, 1)), $urandom_range(0, 4));
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
            play($urandom_range(0, 2), ab, 1'b0, 1'b0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
